// File: rtl/snake_bus_arbiter.sv
// Two-requester arbiter for the shared 5-bit snake coordinate bus.
// Round-robin on contention, hold-limit forced release, all outputs registered.
module snake_bus_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [4:0] ADDR0,
    input  logic       DONE0,
    input  logic       REQ1,
    input  logic [4:0] ADDR1,
    input  logic       DONE1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       SEL,
    output logic [4:0] ADDR_OUT,
    output logic       BUSY,
    output logic       TIMEOUT
);
    // state  | meaning
    // IDLE   | no owner; SEL and ADDR_OUT keep their last values
    // GRANT0 | game-logic writer owns the bus
    // GRANT1 | display reader owns the bus
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [4:0] HOLD_LAST = 5'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] addr_q, addr_d;
    logic       pri_q, pri_d;
    logic       sel_q, sel_d;
    logic       timeout_q, timeout_d;
    logic       gnt0_q, gnt1_q, busy_q;
    logic       own_id, own_req, own_done, oth_req, hold_hit, quit;

    always_comb begin
        own_id    = (state_q == GRANT1);
        own_req   = own_id ? REQ1 : REQ0;
        own_done  = own_id ? DONE1 : DONE0;
        oth_req   = own_id ? REQ0 : REQ1;
        hold_hit  = (cnt_q == HOLD_LAST) && oth_req;
        quit      = own_done || !own_req;
        state_d   = state_q;
        cnt_d     = cnt_q;
        pri_d     = pri_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ0 && (!REQ1 || !pri_q)) begin
                    state_d = GRANT0;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                end else if (REQ1) begin
                    state_d = GRANT1;
                    sel_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT0, GRANT1: begin
                addr_d = own_id ? ADDR1 : ADDR0;
                if (quit || hold_hit) begin
                    pri_d     = !own_id;
                    // an owner that is leaving anyway is not a forced release
                    timeout_d = !quit;
                    if (oth_req) begin
                        state_d = own_id ? GRANT0 : GRANT1;
                        sel_d   = !own_id;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            pri_q     <= 1'b0;
            sel_q     <= 1'b0;
            timeout_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            pri_q     <= pri_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
            gnt0_q    <= (state_d == GRANT0);
            gnt1_q    <= (state_d == GRANT1);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign GNT0     = gnt0_q;
    assign GNT1     = gnt1_q;
    assign SEL      = sel_q;
    assign ADDR_OUT = addr_q;
    assign BUSY     = busy_q;
    assign TIMEOUT  = timeout_q;
endmodule

// File: doc/snake_bus_arbiter.md
SNAKE_BUS_ARBITER -- requirements
Module: snake_bus_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 15, max grant cycles before forced release when the other requester is waiting (legal 2..31).
REQ-002 Port: CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: RESET  input  1  reset, synchronous and active-low.
REQ-004 Port: REQ0  input  1  requester 0 (game-logic writer) requests the shared 5-bit coordinate bus.
REQ-005 Port: ADDR0  input  5  requester 0 coordinate.
REQ-006 Port: DONE0  input  1  requester 0 ends its transfer; one-cycle pulse.
REQ-007 Port: REQ1  input  1  requester 1 (display reader) requests the bus.
REQ-008 Port: ADDR1  input  5  requester 1 coordinate.
REQ-009 Port: DONE1  input  1  requester 1 ends its transfer; one-cycle pulse.
REQ-010 Port: GNT0  output  1  bus granted to requester 0.
REQ-011 Port: GNT1  output  1  bus granted to requester 1.
REQ-012 Port: SEL  output  1  control for the downstream 2:1 5-bit multiplexer; 0 selects IN0/ADDR0, 1 selects IN1/ADDR1.
REQ-013 Port: ADDR_OUT  output  5  registered coordinate of the granted requester.
REQ-014 Port: BUSY  output  1  high whenever GNT0 or GNT1 is high.
REQ-015 Port: TIMEOUT  output  1  one-cycle pulse on forced release.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT0, GRANT1; all outputs SHALL be registered.
REQ-017 GNT0 and GNT1 SHALL never both be high; GNT0=1 iff state is GRANT0, GNT1=1 iff state is GRANT1.
REQ-018 In IDLE with exactly one REQn high, the FSM SHALL enter GRANTn on the next edge (grant latency 1 cycle).
REQ-019 In IDLE with both REQ high, the FSM SHALL grant the requester selected by a round-robin pointer PRI (PRI=0 favours 0); PRI resets to 0.
REQ-020 In GRANTn, SEL SHALL equal n and ADDR_OUT SHALL load ADDRn every cycle (1-cycle latency from ADDRn).
REQ-021 In IDLE, SEL and ADDR_OUT SHALL hold their last values.
REQ-022 A 5-bit hold counter SHALL clear to 0 on entry to any grant state, increment each granted cycle, and saturate at HOLD_MAX-1.
REQ-023 GRANTn SHALL release on the edge where DONEn=1, or REQn=0, or (counter==HOLD_MAX-1 and the other REQ=1).
REQ-024 On release, if the other REQ is high the FSM SHALL move directly to the other grant state (no IDLE cycle); otherwise to IDLE.
REQ-025 On every release from GRANTn, PRI SHALL be set to favour the other requester.
REQ-026 TIMEOUT SHALL pulse for one cycle coincident with the first cycle after a release caused only by the hold limit; DONEn or REQn drop in the same cycle take precedence (no TIMEOUT).
REQ-027 With the other requester idle, a grant SHALL persist beyond HOLD_MAX cycles; counter stays saturated.
REQ-028 DONEn while not in GRANTn SHALL be ignored.
REQ-029 REQn dropping in the same cycle it would be granted in IDLE SHALL still yield a one-cycle grant, then release per REQ-023.

Reset
REQ-030 With RESET=0 at a rising CLK edge: state=IDLE, GNT0=GNT1=0, SEL=0, ADDR_OUT=5'b00000, BUSY=0, TIMEOUT=0, counter=0, PRI=0, regardless of current state or requests.
REQ-031 RESET asserted mid-grant SHALL abort the grant on that edge with no TIMEOUT pulse; first grant after release follows REQ-018/019.

Verification
REQ-032 Reset then REQ0=1, ADDR0=5'd7 -> next cycle GNT0=1, SEL=0, BUSY=1; cycle after ADDR_OUT=7.
REQ-033 From IDLE, REQ0=REQ1=1 after reset -> GNT0 first; DONE0 pulse -> next edge GNT1=1, SEL=1, GNT0=0, no IDLE gap.
REQ-034 HOLD_MAX=15, GRANT1 held, REQ0 raised at grant cycle 3 -> release after 15 granted cycles, TIMEOUT=1 one cycle, GNT0=1 same cycle.
REQ-035 GRANT0 held 40 cycles with REQ1=0 -> GNT0 stays 1, TIMEOUT never pulses.
REQ-036 RESET=0 during GRANT1 with ADDR1=5'd31 -> next edge all outputs 0, ADDR_OUT=0; RESET=1, REQ0=REQ1=1 -> GNT0 granted (PRI=0).
REQ-037 DONE1 pulsed while GRANT0 -> no effect; GNT0 unchanged, PRI unchanged.
